// File: rtl/debug_cmd_sequencer.sv
// debug_cmd_sequencer: UART-side debug controller; loads IM, runs/steps the CPU, dumps PC and register bank over UART.
//   i_clock/i_reset      clock, async active-high reset
//   i_rx_done/i_rx_data  received byte strobe and data
//   i_tx_done            transmitter finished current byte
//   i_halt, i_pc         CPU halt status and program counter
//   i_rb_data/o_rb_addr  register bank debug read port
//   o_im_we/addr/data    instruction memory write port
//   o_cpu_enable         CPU clock enable
//   o_tx_data/o_tx_start byte to transmit and start pulse
//   o_state              one-hot state
module debug_cmd_sequencer #(
  parameter int BYTE     = 8,
  parameter int DWORD    = 32,
  parameter int IM_BYTES = 256,
  parameter int RB_ADDR  = 5,
  parameter int NB_ST    = 10,
  localparam int NB_IMA  = $clog2(IM_BYTES/4)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [BYTE-1:0]    i_rx_data,
  input  logic               i_tx_done,
  input  logic               i_halt,
  input  logic [DWORD-1:0]   i_pc,
  input  logic [DWORD-1:0]   i_rb_data,
  output logic [RB_ADDR-1:0] o_rb_addr,
  output logic               o_im_we,
  output logic [NB_IMA-1:0]  o_im_addr,
  output logic [DWORD-1:0]   o_im_data,
  output logic               o_cpu_enable,
  output logic [BYTE-1:0]    o_tx_data,
  output logic               o_tx_start,
  output logic [NB_ST-1:0]   o_state
);
  localparam int NB_BC  = $clog2(IM_BYTES) + 1;
  localparam int NB_IDX = RB_ADDR + 1;
  localparam int NW     = 2**RB_ADDR;
  typedef enum logic [NB_ST-1:0] {
    IDLE     = NB_ST'(1 << 0),
    LOAD     = NB_ST'(1 << 1),
    IM_WR    = NB_ST'(1 << 2),
    READY    = NB_ST'(1 << 3),
    RUN      = NB_ST'(1 << 4),
    STEP     = NB_ST'(1 << 5),
    LATCH    = NB_ST'(1 << 6),
    TX_START = NB_ST'(1 << 7),
    TX_WAIT  = NB_ST'(1 << 8),
    DONE     = NB_ST'(1 << 9)
  } state_t;
  state_t state_q, state_d;
  logic [DWORD-1:0]  buf_q, buf_d, word_q, word_d, word_sh;
  logic [NB_BC-1:0]  bcnt_q, bcnt_d;
  logic [NB_IMA-1:0] wcnt_q, wcnt_d;
  logic [NB_IDX-1:0] idx_q, idx_d;
  logic [1:0]        bsel_q, bsel_d;
  logic [BYTE-1:0]   tx_q, tx_d, tx_byte;
  logic              loaded_q, loaded_d;
  // MSB-first byte selection: shift the chosen byte into the top lane
  assign word_sh      = word_q << {bsel_q, 3'b000};
  assign tx_byte      = word_sh[DWORD-1 -: BYTE];
  assign o_state      = state_q;
  assign o_im_we      = state_q == IM_WR;
  assign o_im_addr    = wcnt_q;
  assign o_im_data    = buf_q;
  assign o_cpu_enable = state_q == RUN ? ~i_halt : state_q == STEP;
  assign o_tx_start   = state_q == TX_START;
  assign o_tx_data    = state_q == TX_START ? tx_byte : tx_q;
  // dump index 0 is the PC, so register k-1 is read for index k
  assign o_rb_addr    = state_q == LATCH ? RB_ADDR'(idx_q - 1'b1) : '0;
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    bcnt_d   = bcnt_q;
    wcnt_d   = wcnt_q;
    loaded_d = loaded_q;
    idx_d    = idx_q;
    bsel_d   = bsel_q;
    word_d   = word_q;
    tx_d     = tx_q;
    case (state_q)
      IDLE: if (i_rx_done && i_rx_data == BYTE'(1)) begin
        state_d = LOAD;
        bcnt_d  = '0;
        wcnt_d  = '0;
      end
      LOAD: if (i_rx_done) begin
        buf_d  = {buf_q[DWORD-BYTE-1:0], i_rx_data};
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q[1:0] == 2'd3) state_d = IM_WR;
      end
      IM_WR: begin
        wcnt_d = wcnt_q + 1'b1;
        if (bcnt_q == NB_BC'(IM_BYTES)) begin
          loaded_d = 1'b1;
          state_d  = READY;
        end else state_d = LOAD;
      end
      READY: if (i_rx_done) begin
        if (i_rx_data == BYTE'(1)) begin
          state_d  = LOAD;
          bcnt_d   = '0;
          wcnt_d   = '0;
          loaded_d = 1'b0;
        end else if (loaded_q && i_rx_data == BYTE'(2)) state_d = i_halt ? LATCH : RUN;
        else if (loaded_q && i_rx_data == BYTE'(3)) state_d = i_halt ? LATCH : STEP;
      end
      RUN: if (i_halt) state_d = LATCH;
      STEP: state_d = LATCH;
      LATCH: begin
        word_d  = idx_q == '0 ? i_pc : i_rb_data;
        bsel_d  = '0;
        state_d = TX_START;
      end
      TX_START: begin
        tx_d    = tx_byte;
        state_d = TX_WAIT;
      end
      TX_WAIT: if (i_tx_done) begin
        if (bsel_q != 2'd3) begin
          bsel_d  = bsel_q + 1'b1;
          state_d = TX_START;
        end else if (idx_q == NB_IDX'(NW)) state_d = DONE;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = LATCH;
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      bcnt_q   <= '0;
      wcnt_q   <= '0;
      loaded_q <= 1'b0;
      idx_q    <= '0;
      bsel_q   <= '0;
      word_q   <= '0;
      tx_q     <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      bcnt_q   <= bcnt_d;
      wcnt_q   <= wcnt_d;
      loaded_q <= loaded_d;
      idx_q    <= idx_d;
      bsel_q   <= bsel_d;
      word_q   <= word_d;
      tx_q     <= tx_d;
    end
  end
endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// tb_debug_cmd_sequencer: scoreboard bench for debug_cmd_sequencer with random program/register data.
module tb_debug_cmd_sequencer;
  logic        clk = 0, rst = 1, rx_done = 0, tx_done = 0, halt = 0;
  logic [7:0]  rx_data = 0, tx_data;
  logic [31:0] pc = 0, rb_data, im_data;
  logic [4:0]  rb_addr;
  logic [5:0]  im_addr;
  logic        im_we, cpu_en, tx_start;
  logic [9:0]  state;
  logic [31:0] regs [32];
  logic [37:0] im_q [$];
  logic [7:0]  tx_q [$];
  int checks = 0, errors = 0, en_cnt = 0;
  debug_cmd_sequencer dut (
    .i_clock(clk), .i_reset(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_tx_done(tx_done), .i_halt(halt), .i_pc(pc), .i_rb_data(rb_data),
    .o_rb_addr(rb_addr), .o_im_we(im_we), .o_im_addr(im_addr), .o_im_data(im_data),
    .o_cpu_enable(cpu_en), .o_tx_data(tx_data), .o_tx_start(tx_start), .o_state(state)
  );
  assign rb_data = regs[rb_addr];
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [37:0] e;
    if (!rst) begin
      if (im_we) begin
        if (im_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL im_unexpected: got addr=%0d data=%h expected no write", im_addr, im_data);
        end else begin
          e = im_q.pop_front();
          chk("im_addr", 64'(im_addr), 64'(e[37:32]));
          chk("im_data", 64'(im_data), 64'(e[31:0]));
        end
      end
      if (tx_start) begin
        if (tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
        end else chk("tx_byte", 64'(tx_data), 64'(tx_q.pop_front()));
      end
      if (cpu_en) en_cnt++;
    end
  end
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      repeat (2) @(posedge clk);
      #1 tx_done = 1;
      @(posedge clk);
      #1 tx_done = 0;
    end
  end
  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b; rx_done = 1;
    @(posedge clk);
    #1 rx_done = 0;
    repeat (3) @(posedge clk);
  endtask
  task automatic wait_st(input int bitn, input int budget, input string name);
    int n = 0;
    while (!state[bitn] && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!state[bitn]) begin
      errors++;
      $display("FAIL %s: got state %b expected bit %0d set", name, state, bitn);
    end
  endtask
  task automatic load(input int nbytes, input bit seq);
    logic [31:0] w;
    send(8'd1);
    for (int i = 0; i < 64 && 4*i < nbytes; i++) begin
      w = seq ? 32'(i + 1) : $urandom;
      if (4*i + 4 <= nbytes) im_q.push_back({6'(i), w});
      for (int k = 3; k >= 0 && 4*i + (3-k) < nbytes; k--) send(w[8*k +: 8]);
    end
  endtask
  task automatic expect_dump();
    pc = $urandom;
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    for (int k = 3; k >= 0; k--) tx_q.push_back(pc[8*k +: 8]);
    for (int r = 0; r < 32; r++)
      for (int k = 3; k >= 0; k--) tx_q.push_back(regs[r][8*k +: 8]);
  endtask
  initial begin
    int n;
    for (int r = 0; r < 32; r++) regs[r] = 0;
    #50;
    chk("reset_state", 64'(state), 64'h1);
    chk("reset_im_we", 64'(im_we), 0);
    chk("reset_tx_start", 64'(tx_start), 0);
    chk("reset_cpu_en", 64'(cpu_en), 0);
    #50 rst = 0;
    send(8'd2);
    repeat (10) @(negedge clk);
    chk("idle_ignores_run", 64'(state), 64'h1);
    chk("idle_no_enable", 64'(en_cnt), 0);
    load(256, 1);
    wait_st(3, 50, "load_ready");
    chk("load_all_words", 64'(im_q.size()), 0);
    en_cnt = 0;
    expect_dump();
    send(8'd3);
    wait_st(9, 3000, "step_done");
    wait_st(3, 10, "step_ready");
    chk("step_enable_cycles", 64'(en_cnt), 1);
    chk("step_dump_len", 64'(tx_q.size()), 0);
    send(8'd7);
    repeat (5) @(negedge clk);
    chk("ready_ignores_bad", 64'(state), 64'h8);
    en_cnt = 0;
    expect_dump();
    send(8'd2);
    n = 0;
    while (en_cnt < 50 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("run_reached_50", 64'(en_cnt), 50);
    #1 halt = 1;
    @(negedge clk);
    chk("run_enable_drops", 64'(cpu_en), 0);
    chk("run_still_run", 64'(state), 64'h10);
    wait_st(9, 3000, "run_done");
    wait_st(3, 10, "run_ready");
    chk("run_enable_cycles", 64'(en_cnt), 50);
    chk("run_dump_len", 64'(tx_q.size()), 0);
    en_cnt = 0;
    expect_dump();
    send(8'd3);
    wait_st(9, 3000, "halted_done");
    wait_st(3, 10, "halted_ready");
    chk("halted_no_enable", 64'(en_cnt), 0);
    chk("halted_dump_len", 64'(tx_q.size()), 0);
    halt = 0;
    load(256, 0);
    wait_st(3, 50, "reload_ready");
    chk("reload_all_words", 64'(im_q.size()), 0);
    load(130, 0);
    chk("partial_words", 64'(im_q.size()), 0);
    @(posedge clk);
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("midload_reset_state", 64'(state), 64'h1);
    rst = 0;
    send(8'd3);
    repeat (5) @(negedge clk);
    chk("after_reset_idle", 64'(state), 64'h1);
    load(256, 0);
    wait_st(3, 50, "restart_ready");
    chk("restart_all_words", 64'(im_q.size()), 0);
    chk("restart_no_enable", 64'(en_cnt), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
